// File: rtl/maj_voter_pkg.sv
// Shared definitions for the sequential majority voter: per-channel health
// state encodings and the sizing helper for the consecutive-mismatch counter.
package maj_voter_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAILED  = 2'd2
  } ch_state_e;

  // Smallest counter width able to hold the value fail_thresh.
  function automatic int fail_cnt_width(input int fail_thresh);
    return (fail_thresh < 2) ? 1 : $clog2(fail_thresh + 1);
  endfunction

endpackage

// File: rtl/maj_channel_monitor.sv
// Health tracker for one voter channel: counts consecutive mismatching samples
// and latches a sticky fault once the run reaches FAIL_THRESH.
module maj_channel_monitor
  import maj_voter_pkg::*;
#(
  parameter int FAIL_THRESH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic mismatch,
  input  logic clear,
  output logic fault
);

  localparam int                CntW      = fail_cnt_width(FAIL_THRESH);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam logic [CntW-1:0]   ThreshCnt = CntW'(FAIL_THRESH);

  ch_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            fault_q;

  // NOTE: reset is sampled on the clock edge, so it lives inside the
  // sequential block and every state register uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= ST_OK;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else if (sample_en) begin
      unique case (state_q)
        ST_OK: begin
          if (mismatch) begin
            cnt_q <= CntOne;
            if (FAIL_THRESH == 1) begin
              state_q <= ST_FAILED;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_SUSPECT;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        ST_SUSPECT: begin
          if (mismatch) begin
            cnt_q <= cnt_q + CntOne;
            if ((cnt_q + CntOne) == ThreshCnt) begin
              state_q <= ST_FAILED;
              fault_q <= 1'b1;
            end
          end else begin
            state_q <= ST_OK;
            cnt_q   <= '0;
          end
        end
        ST_FAILED: state_q <= ST_FAILED;  // sticky until clear or reset
        default: begin
          state_q <= ST_OK;
          cnt_q   <= '0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/majority_voter_seq.sv
// Registered bitwise majority voter over NUM_CH redundant channels with
// per-channel fault tracking. Define MAJORITY_VOTER_STATS_EN for mismatch_events.
module majority_voter_seq
  import maj_voter_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int WIDTH       = 8,
  parameter int FAIL_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    clear_faults,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    disagree,
  output logic [NUM_CH-1:0]       ch_fault
`ifdef MAJORITY_VOTER_STATS_EN
  ,
  output logic [CNT_W-1:0]        mismatch_events
`endif
);

  logic [WIDTH-1:0]  vote_d;
  logic [NUM_CH-1:0] mismatch_d;
  logic              disagree_d;

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              disagree_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin : p_vote
    int ones;
    ones   = 0;
    vote_d = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        ones = ones + int'(in_data[k*WIDTH + b]);
      end
      vote_d[b] = (ones > NUM_CH / 2);
    end
  end

  always_comb begin
    mismatch_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      mismatch_d[k] = (in_data[k*WIDTH +: WIDTH] != vote_d);
    end
    disagree_d = |mismatch_d;
  end

  // Result registers only load on accepted samples, so they hold across idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      disagree_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_data_q <= vote_d;
        disagree_q <= disagree_d;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_mon
    maj_channel_monitor #(
      .FAIL_THRESH(FAIL_THRESH)
    ) u_mon (
      .clk      (clk),
      .rst_n    (rst_n),
      .sample_en(in_valid),
      .mismatch (mismatch_d[k]),
      .clear    (clear_faults),
      .fault    (ch_fault[k])
    );
  end

`ifdef MAJORITY_VOTER_STATS_EN
  logic [CNT_W-1:0] events_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_faults) begin
      events_q <= '0;
    end else if (in_valid && disagree_d && (events_q != '1)) begin
      events_q <= events_q + CNT_W'(1);
    end
  end

  assign mismatch_events = events_q;
`else
  logic [CNT_W-1:0] unused_stats;
  assign unused_stats = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign disagree  = disagree_q;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Self-checking bench for majority_voter_seq: a behavioural model tracks the
// expected outputs of a FAIL_THRESH=3 and a FAIL_THRESH=1 instance every cycle.
module tb_majority_voter_seq;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;
  localparam int CNT_W  = 8;
  localparam int DW     = NUM_CH * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          clear_faults;

  logic              out_valid   [2];
  logic [WIDTH-1:0]  out_data    [2];
  logic              disagree    [2];
  logic [NUM_CH-1:0] ch_fault    [2];
`ifdef MAJORITY_VOTER_STATS_EN
  logic [CNT_W-1:0]  mismatch_events [2];
`endif

  always #5 clk = ~clk;

  majority_voter_seq #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .FAIL_THRESH(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear_faults(clear_faults), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .disagree(disagree[0]), .ch_fault(ch_fault[0])
`ifdef MAJORITY_VOTER_STATS_EN
    , .mismatch_events(mismatch_events[0])
`endif
  );

  majority_voter_seq #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .FAIL_THRESH(1), .CNT_W(CNT_W)) dut_t1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear_faults(clear_faults), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .disagree(disagree[1]), .ch_fault(ch_fault[1])
`ifdef MAJORITY_VOTER_STATS_EN
    , .mismatch_events(mismatch_events[1])
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: majority by counting ones, fault = run of mismatches reached threshold.
  int               th [2] = '{3, 1};
  int               run_m [2][NUM_CH];
  logic [NUM_CH-1:0] flt_m [2];
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_dis;
  int               exp_events;
  bit               cmp_en = 1'b0;

  function automatic logic [WIDTH-1:0] vote(input logic [DW-1:0] d);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int b = 0; b < WIDTH; b++) begin
      int ones = 0;
      for (int k = 0; k < NUM_CH; k++) ones += int'(d[k*WIDTH + b]);
      v[b] = (ones > NUM_CH / 2);
    end
    return v;
  endfunction

  task automatic model_update();
    logic [NUM_CH-1:0] mm;
    mm = '0;
    if (!rst_n) begin
      exp_valid = 1'b0; exp_data = '0; exp_dis = 1'b0; exp_events = 0;
      for (int t = 0; t < 2; t++) begin
        flt_m[t] = '0;
        for (int k = 0; k < NUM_CH; k++) run_m[t][k] = 0;
      end
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        exp_data = vote(in_data);
        for (int k = 0; k < NUM_CH; k++) mm[k] = (in_data[k*WIDTH +: WIDTH] != exp_data);
        exp_dis = |mm;
      end
      if (clear_faults) begin
        exp_events = 0;
        for (int t = 0; t < 2; t++) begin
          flt_m[t] = '0;
          for (int k = 0; k < NUM_CH; k++) run_m[t][k] = 0;
        end
      end else if (in_valid) begin
        for (int t = 0; t < 2; t++)
          for (int k = 0; k < NUM_CH; k++)
            if (!flt_m[t][k]) begin
              run_m[t][k] = mm[k] ? run_m[t][k] + 1 : 0;
              if (run_m[t][k] >= th[t]) flt_m[t][k] = 1'b1;
            end
        if (exp_dis && exp_events < (1 << CNT_W) - 1) exp_events++;
      end
    end
  endtask

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int t = 0; t < 2; t++) begin
        check($sformatf("out_valid[t%0d]", t), 32'(out_valid[t]), 32'(exp_valid));
        check($sformatf("out_data[t%0d]", t),  32'(out_data[t]),  32'(exp_data));
        check($sformatf("disagree[t%0d]", t),  32'(disagree[t]),  32'(exp_dis));
        check($sformatf("ch_fault[t%0d]", t),  32'(ch_fault[t]),  32'(flt_m[t]));
`ifdef MAJORITY_VOTER_STATS_EN
        check($sformatf("mismatch_events[t%0d]", t), 32'(mismatch_events[t]), 32'(exp_events));
`endif
      end
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic clr, input logic r);
    rst_n = r; in_valid = v; in_data = d; clear_faults = clr;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  localparam logic [DW-1:0] S_A5   = {8'h5A, 8'hA5, 8'hA5};
  localparam logic [DW-1:0] S_MIX  = {8'hF0, 8'h3C, 8'h0F};
  localparam logic [DW-1:0] S_CH1  = {8'h00, 8'hFF, 8'h00};
  localparam logic [DW-1:0] S_AGR  = {8'h11, 8'h11, 8'h11};
  localparam logic [DW-1:0] S_CH0M = {8'hAA, 8'hAA, 8'h55};
  localparam logic [DW-1:0] S_CH0K = {8'hAA, 8'hAA, 8'hAA};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear_faults = 1'b0;
    cmp_en = 1'b1;

    // Reset held two cycles with a valid sample present.
    step(1, S_A5, 0, 0);
    step(1, S_A5, 0, 0);
    check("pin_reset_valid", 32'(exp_valid), 32'h0);
    check("pin_reset_data",  32'(exp_data),  32'h00);
    check("pin_reset_fault", 32'(flt_m[0]),  32'h0);

    // Single sample, ch2 disagrees.
    step(1, S_A5, 0, 1);
    check("pin_a5_data",  32'(exp_data), 32'hA5);
    check("pin_a5_dis",   32'(exp_dis),  32'h1);
    check("pin_a5_flt3",  32'(flt_m[0]), 32'h0);
    check("pin_a5_run2",  32'(run_m[0][2]), 32'h1);
    check("pin_a5_flt1",  32'(flt_m[1]), 32'h4);
    step(0, S_MIX, 0, 1);
    check("pin_idle_hold", 32'(exp_data), 32'hA5);
    step(0, '0, 1, 1);

    // Three-way split vote.
    step(1, S_MIX, 0, 1);
    check("pin_mix_data", 32'(exp_data), 32'h3C);
    check("pin_mix_dis",  32'(exp_dis),  32'h1);
    step(0, '0, 1, 1);

    // ch1 faults on the third consecutive mismatch, stays sticky, then clears.
    step(1, S_CH1, 0, 1);
    step(1, S_CH1, 0, 1);
    check("pin_ch1_two", 32'(flt_m[0]), 32'h0);
    step(1, S_CH1, 0, 1);
    check("pin_ch1_three", 32'(flt_m[0]), 32'h2);
    step(1, S_AGR, 0, 1);
    step(1, S_AGR, 0, 1);
    check("pin_ch1_sticky", 32'(flt_m[0]), 32'h2);
    check("pin_agree_dis",  32'(exp_dis),  32'h0);
    step(0, '0, 1, 1);
    check("pin_clear", 32'(flt_m[0]), 32'h0);

    // ch0: mismatch, match, mismatch, mismatch never reaches three in a row.
    step(1, S_CH0M, 0, 1);
    check("pin_t1_immediate", 32'(flt_m[1]), 32'h1);
    step(1, S_CH0K, 0, 1);
    step(1, S_CH0M, 0, 1);
    step(1, S_CH0M, 0, 1);
    check("pin_ch0_broken_run", 32'(flt_m[0]), 32'h0);

    // Clear alongside a valid sample: output produced, FSM effect overridden.
    step(1, S_CH0M, 1, 1);
    check("pin_clr_valid_out", 32'(exp_valid), 32'h1);
    check("pin_clr_valid_run", 32'(run_m[0][0]), 32'h0);
    step(1, S_CH0M, 0, 1);
    check("pin_clr_valid_flt", 32'(flt_m[0]), 32'h0);
    step(1, S_CH0M, 0, 1);
    step(1, S_CH0M, 0, 1);
    check("pin_ch0_failed", 32'(flt_m[0]), 32'h1);

    // Reset pulse in the middle of a valid stream.
    step(1, S_CH0M, 0, 0);
    check("pin_midrst_valid", 32'(exp_valid), 32'h0);
    check("pin_midrst_flt",   32'(flt_m[0]),  32'h0);
    step(1, S_CH0K, 0, 1);
    check("pin_after_rst_valid", 32'(exp_valid), 32'h1);

`ifdef MAJORITY_VOTER_STATS_EN
    step(0, '0, 1, 1);
    for (int i = 0; i < 300; i++) step(1, S_CH1, 0, 1);
    check("pin_events_sat", 32'(exp_events), 32'd255);
    step(1, S_CH1, 1, 1);
    check("pin_events_clear", 32'(exp_events), 32'd0);
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
